// File: rtl/actor_move_scheduler_pkg.sv
// Shared types and maze geometry for the per-frame actor move scheduler.
// Direction encoding, scheduler states and the tile-index helper live here.
package actor_move_scheduler_pkg;

   typedef enum logic [1:0] {
      DIR_R = 2'd0,
      DIR_L = 2'd1,
      DIR_U = 2'd2,
      DIR_D = 2'd3
   } dir_e;

   localparam logic [9:0] IMG_X0  = 10'd208;
   localparam logic [9:0] IMG_Y0  = 10'd96;
   localparam int         TILE_W  = 8;
   localparam int         TILES_X = 28;
   localparam int         TILES_Y = 36;

   typedef enum logic [3:0] {
      IDLE,
      SEL,
      RD_REQ,
      WT_REQ,
      RD_CUR,
      WT_CUR,
      MOVE,
      NEXT,
      FIN
   } state_e;

   // y*28 built from shifts so no multiplier is inferred.
   function automatic logic [9:0] tile_index(input logic [6:0] x, input logic [6:0] y);
      logic [9:0] yy;
      yy = {3'b000, y};
      return (yy << 5) - (yy << 2) + {3'b000, x};
   endfunction

endpackage

// File: rtl/actor_move_scheduler_tile_neighbor.sv
// Neighbour-tile lookup: map index of the tile next to (tx,ty) in direction d,
// with off_grid set when that neighbour lies outside the maze.
module actor_move_scheduler_tile_neighbor
   import actor_move_scheduler_pkg::*;
(
   input  logic [6:0] tx,
   input  logic [6:0] ty,
   input  dir_e       d,
   output logic [9:0] idx,
   output logic       off_grid
);

   logic [6:0] nx;
   logic [6:0] ny;

   // NOTE: every output gets a default before the case so no path leaves a latch.
   always_comb begin
      nx       = tx;
      ny       = ty;
      off_grid = 1'b0;
      case (d)
         DIR_R: if (tx == 7'(TILES_X - 1)) off_grid = 1'b1; else nx = tx + 7'd1;
         DIR_L: if (tx == 7'd0)            off_grid = 1'b1; else nx = tx - 7'd1;
         DIR_U: if (ty == 7'd0)            off_grid = 1'b1; else ny = ty - 7'd1;
         DIR_D: if (ty == 7'(TILES_Y - 1)) off_grid = 1'b1; else ny = ty + 7'd1;
         default: off_grid = 1'b1;
      endcase
      idx = tile_index(nx, ny);
   end

endmodule

// File: rtl/actor_move_scheduler.sv
// Steps up to N_ACT maze actors by one pixel per frame, checking walls through
// a single shared synchronous tile-map read port.
module actor_move_scheduler
   import actor_move_scheduler_pkg::*;
#(
   parameter int N_ACT = 4
) (
   input  logic               pclk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic [N_ACT-1:0]   step_en,
   input  logic [2*N_ACT-1:0] req_dir,
   input  logic               ld_en,
   input  logic [1:0]         ld_id,
   input  logic [9:0]         ld_x,
   input  logic [9:0]         ld_y,
   input  logic [1:0]         ld_dir,
   output logic               map_rd,
   output logic [9:0]         map_idx,
   input  logic               map_wall,
   output logic [10*N_ACT-1:0] pos_x,
   output logic [10*N_ACT-1:0] pos_y,
   output logic [2*N_ACT-1:0] dir,
   output logic               busy,
   output logic               done,
   output logic               overrun
);

   localparam int IW = (N_ACT > 1) ? $clog2(N_ACT) : 1;
   localparam logic [9:0] X_RST = IMG_X0 + 10'd116;
   localparam logic [9:0] Y_RST = IMG_Y0 + 10'd212;

   state_e          state_r, state_nx;
   logic [IW-1:0]   idx_r;
   logic [9:0]      ax_r [N_ACT];
   logic [9:0]      ay_r [N_ACT];
   dir_e            ad_r [N_ACT];
   logic [N_ACT-1:0] en_s_r;
   dir_e            req_s_r [N_ACT];

   logic [9:0] cur_x, cur_y, lx, ly;
   dir_e       cur_dir, cur_req, nb_dir;
   logic       in_maze, aligned, nb_off, set_dir;
   logic [9:0] nb_idx;

   assign cur_x   = ax_r[idx_r];
   assign cur_y   = ay_r[idx_r];
   assign cur_dir = ad_r[idx_r];
   assign cur_req = req_s_r[idx_r];
   assign lx      = cur_x - IMG_X0;
   assign ly      = cur_y - IMG_Y0;
   assign in_maze = (lx < 10'(TILE_W * TILES_X)) && (ly < 10'(TILE_W * TILES_Y));
   assign aligned = (lx[2:0] == 3'd4) && (ly[2:0] == 3'd4);
   assign nb_dir  = (state_r == RD_REQ || state_r == WT_REQ) ? cur_req : cur_dir;

   actor_move_scheduler_tile_neighbor u_nb (
      .tx       (lx[9:3]),
      .ty       (ly[9:3]),
      .d        (nb_dir),
      .idx      (nb_idx),
      .off_grid (nb_off)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nx;
   end

   always_comb begin
      state_nx = state_r;
      map_rd   = 1'b0;
      map_idx  = '0;
      done     = 1'b0;
      case (state_r)
         IDLE: if (frame_tick) state_nx = SEL;
         SEL: begin
            if (!en_s_r[idx_r] || !in_maze)                  state_nx = NEXT;
            else if (cur_req == dir_e'(cur_dir ^ 2'b01))     state_nx = MOVE;
            else if (cur_req != cur_dir && aligned)          state_nx = RD_REQ;
            else                                             state_nx = RD_CUR;
         end
         RD_REQ: begin
            if (nb_off) state_nx = RD_CUR;
            else begin
               map_rd   = 1'b1;
               map_idx  = nb_idx;
               state_nx = WT_REQ;
            end
         end
         WT_REQ: begin
            map_idx  = nb_idx;
            state_nx = map_wall ? RD_CUR : MOVE;
         end
         // Mid-tile travel never needs a wall check.
         RD_CUR: begin
            if (!aligned)    state_nx = MOVE;
            else if (nb_off) state_nx = NEXT;
            else begin
               map_rd   = 1'b1;
               map_idx  = nb_idx;
               state_nx = WT_CUR;
            end
         end
         WT_CUR: begin
            map_idx  = nb_idx;
            state_nx = map_wall ? NEXT : MOVE;
         end
         MOVE: state_nx = NEXT;
         NEXT: state_nx = (idx_r == IW'(N_ACT - 1)) ? FIN : SEL;
         FIN: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign set_dir = (state_r == SEL || state_r == WT_REQ) && (state_nx == MOVE);

   // NOTE: actor state is a handful of flops, not a RAM, so it is reset along with everything else.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ACT; i++) begin
            ax_r[i]    <= X_RST;
            ay_r[i]    <= Y_RST;
            ad_r[i]    <= DIR_L;
            req_s_r[i] <= DIR_L;
         end
         en_s_r  <= '0;
         idx_r   <= '0;
         overrun <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so the load and the snapshot in one IDLE cycle both see pre-edge values.
         if (state_r == IDLE) begin
            if (ld_en && int'(ld_id) < N_ACT) begin
               ax_r[ld_id] <= ld_x;
               ay_r[ld_id] <= ld_y;
               ad_r[ld_id] <= dir_e'(ld_dir);
            end
            if (frame_tick) begin
               en_s_r <= step_en;
               idx_r  <= '0;
               for (int i = 0; i < N_ACT; i++) req_s_r[i] <= dir_e'(req_dir[2*i +: 2]);
            end
         end else if (frame_tick) begin
            overrun <= 1'b1;
         end

         if (set_dir) ad_r[idx_r] <= cur_req;

         if (state_r == MOVE) begin
            case (cur_dir)
               DIR_R: ax_r[idx_r] <= cur_x + 10'd1;
               DIR_L: ax_r[idx_r] <= cur_x - 10'd1;
               DIR_U: ay_r[idx_r] <= cur_y - 10'd1;
               DIR_D: ay_r[idx_r] <= cur_y + 10'd1;
               default: ;
            endcase
         end

         if (state_r == NEXT) idx_r <= idx_r + IW'(1);
      end
   end

   for (genvar g = 0; g < N_ACT; g++) begin : g_out
      assign pos_x[10*g +: 10] = ax_r[g];
      assign pos_y[10*g +: 10] = ay_r[g];
      assign dir[2*g +: 2]     = ad_r[g];
   end

   assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_actor_move_scheduler.sv
// Self-checking bench: directed scenarios plus randomized frames against a
// per-frame behavioural model of actor movement and expected map reads.
module tb_actor_move_scheduler;
   import actor_move_scheduler_pkg::*;

   localparam int N = 4;

   logic          pclk;
   logic          rst_n;
   logic          frame_tick;
   logic [N-1:0]  step_en;
   logic [2*N-1:0] req_dir;
   logic          ld_en;
   logic [1:0]    ld_id;
   logic [9:0]    ld_x, ld_y;
   logic [1:0]    ld_dir;
   logic          map_rd;
   logic [9:0]    map_idx;
   logic          map_wall = 1'b0;
   logic [10*N-1:0] pos_x, pos_y;
   logic [2*N-1:0] dir;
   logic          busy, done, overrun;

   actor_move_scheduler #(.N_ACT(N)) dut (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .step_en    (step_en),
      .req_dir    (req_dir),
      .ld_en      (ld_en),
      .ld_id      (ld_id),
      .ld_x       (ld_x),
      .ld_y       (ld_y),
      .ld_dir     (ld_dir),
      .map_rd     (map_rd),
      .map_idx    (map_idx),
      .map_wall   (map_wall),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   bit wall_map [0:1023];
   int got_reads[$];
   int exp_reads[$];
   int mx[N], my[N], md[N];
   int n_checks = 0;
   int n_fail   = 0;

   // Tile map with one-cycle read latency; garbage on cycles without a read.
   always @(posedge pclk) map_wall <= map_rd ? wall_map[map_idx] : 1'($urandom);

   always @(negedge pclk) if (map_rd) got_reads.push_back(int'(map_idx));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Wall test for the tile beside (tx,ty); records the read it would need.
   function automatic bit blocked(input int tx, input int ty, input int d);
      int nx = tx;
      int ny = ty;
      case (d)
         0: nx = tx + 1;
         1: nx = tx - 1;
         2: ny = ty - 1;
         default: ny = ty + 1;
      endcase
      if (nx < 0 || nx >= TILES_X || ny < 0 || ny >= TILES_Y) return 1'b1;
      exp_reads.push_back(ny * TILES_X + nx);
      return wall_map[ny * TILES_X + nx];
   endfunction

   function automatic void step(input int i);
      case (md[i])
         0: mx[i] = (mx[i] + 1) % 1024;
         1: mx[i] = (mx[i] + 1023) % 1024;
         2: my[i] = (my[i] + 1023) % 1024;
         default: my[i] = (my[i] + 1) % 1024;
      endcase
   endfunction

   function automatic void model_frame(input logic [N-1:0] en, input logic [2*N-1:0] req);
      for (int i = 0; i < N; i++) begin
         int lx, ly, tx, ty, r;
         bit al;
         if (!en[i]) continue;
         lx = (mx[i] - 208 + 1024) % 1024;
         ly = (my[i] - 96 + 1024) % 1024;
         if (!(lx < 8 * TILES_X && ly < 8 * TILES_Y)) continue;
         al = (lx % 8 == 4) && (ly % 8 == 4);
         tx = lx / 8;
         ty = ly / 8;
         r  = int'(req[2*i +: 2]);
         if (r == (md[i] ^ 1)) begin
            md[i] = r;
            step(i);
            continue;
         end
         if (r != md[i] && al && !blocked(tx, ty, r)) begin
            md[i] = r;
            step(i);
            continue;
         end
         if (!al) step(i);
         else if (!blocked(tx, ty, md[i])) step(i);
      end
   endfunction

   task automatic load(input int id, input int x, input int y, input int d);
      @(negedge pclk);
      ld_en = 1'b1; ld_id = 2'(id); ld_x = 10'(x); ld_y = 10'(y); ld_dir = 2'(d);
      @(negedge pclk);
      ld_en = 1'b0;
      mx[id] = x % 1024; my[id] = y % 1024; md[id] = d;
   endtask

   task automatic run_frame(input logic [N-1:0] en, input logic [2*N-1:0] req, input bit do_ld,
                            input int id, input int x, input int y, input int d, input int inject_at);
      int c;
      exp_reads.delete();
      got_reads.delete();
      if (do_ld) begin
         mx[id] = x % 1024; my[id] = y % 1024; md[id] = d;
      end
      model_frame(en, req);
      @(negedge pclk);
      frame_tick = 1'b1; step_en = en; req_dir = req;
      if (do_ld) begin
         ld_en = 1'b1; ld_id = 2'(id); ld_x = 10'(x); ld_y = 10'(y); ld_dir = 2'(d);
      end
      @(negedge pclk);
      frame_tick = 1'b0; ld_en = 1'b0;
      c = 0;
      while (!done && c < 200) begin
         @(negedge pclk);
         c++;
         if (c == inject_at) begin
            frame_tick = 1'b1; ld_en = 1'b1; ld_id = 2'd0;
            ld_x = 10'd500; ld_y = 10'd500; ld_dir = 2'd3;
         end else begin
            frame_tick = 1'b0; ld_en = 1'b0;
         end
      end
      frame_tick = 1'b0; ld_en = 1'b0;
      check("done_seen", 32'(done), 32'd1);
      @(negedge pclk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after", 32'(busy), 32'd0);
      check("n_reads", 32'(got_reads.size()), 32'(exp_reads.size()));
      for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++)
         check($sformatf("rd_idx%0d", i), 32'(got_reads[i]), 32'(exp_reads[i]));
      for (int i = 0; i < N; i++) begin
         check($sformatf("pos_x%0d", i), 32'(pos_x[10*i +: 10]), 32'(mx[i]));
         check($sformatf("pos_y%0d", i), 32'(pos_y[10*i +: 10]), 32'(my[i]));
         check($sformatf("dir%0d", i),   32'(dir[2*i +: 2]),     32'(md[i]));
      end
   endtask

   function automatic int rand_coord(input int org, input int ntiles);
      int r = int'($urandom % 10);
      if (r == 0) return int'($urandom % 1024);
      if (r < 3)  return org + 8 * int'($urandom % ntiles) + int'($urandom % 8);
      return org + 8 * int'($urandom % ntiles) + 4;
   endfunction

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; step_en = '0; req_dir = '0;
      ld_en = 1'b0; ld_id = '0; ld_x = '0; ld_y = '0; ld_dir = '0;
      for (int i = 0; i < 1024; i++) wall_map[i] = 1'b0;
      for (int i = 0; i < N; i++) begin
         mx[i] = 324; my[i] = 308; md[i] = 1;
      end
      #23;
      @(negedge pclk);
      rst_n = 1'b1;
      @(negedge pclk);

      for (int i = 0; i < N; i++) begin
         check($sformatf("rst_x%0d", i),   32'(pos_x[10*i +: 10]), 32'd324);
         check($sformatf("rst_y%0d", i),   32'(pos_y[10*i +: 10]), 32'd308);
         check($sformatf("rst_dir%0d", i), 32'(dir[2*i +: 2]),     32'd1);
      end
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_map_rd", 32'(map_rd), 32'd0);
      check("rst_map_idx", 32'(map_idx), 32'd0);

      // Actor 0 keeps going left on an open map.
      run_frame(4'b0001, 8'b01_01_01_01, 1'b0, 0, 0, 0, 0, -1);
      check("t1_x", 32'(pos_x[9:0]), 32'd323);
      check("t1_nrd", 32'(got_reads.size()), 32'd1);
      if (got_reads.size() > 0) check("t1_idx", 32'(got_reads[0]), 32'd741);

      // Turn up refused by a wall, falls back to the current direction.
      wall_map[714] = 1'b1;
      run_frame(4'b0001, 8'b01_01_01_10, 1'b1, 0, 324, 308, 1, -1);
      check("t2_x", 32'(pos_x[9:0]), 32'd323);
      check("t2_dir", 32'(dir[1:0]), 32'd1);
      check("t2_nrd", 32'(got_reads.size()), 32'd2);

      // Same turn with the tile above open.
      wall_map[714] = 1'b0;
      run_frame(4'b0001, 8'b01_01_01_10, 1'b1, 0, 324, 308, 1, -1);
      check("t3_y", 32'(pos_y[9:0]), 32'd307);
      check("t3_dir", 32'(dir[1:0]), 32'd2);
      check("t3_nrd", 32'(got_reads.size()), 32'd1);

      // Reversal mid-tile: no read.
      load(0, 213, 308, 1);
      run_frame(4'b0001, 8'b01_01_01_00, 1'b0, 0, 0, 0, 0, -1);
      check("t4_x", 32'(pos_x[9:0]), 32'd214);
      check("t4_dir", 32'(dir[1:0]), 32'd0);
      check("t4_nrd", 32'(got_reads.size()), 32'd0);

      // Left edge of the grid acts as a wall.
      load(0, 212, 308, 1);
      run_frame(4'b0001, 8'b01_01_01_01, 1'b0, 0, 0, 0, 0, -1);
      check("t5_x", 32'(pos_x[9:0]), 32'd212);
      check("t5_nrd", 32'(got_reads.size()), 32'd0);
      check("t5_overrun", 32'(overrun), 32'd0);

      // Second tick and a load mid-pass: flagged, load ignored.
      run_frame(4'b1111, 8'b00_10_11_01, 1'b0, 0, 0, 0, 0, 3);
      check("t6_overrun", 32'(overrun), 32'd1);

      for (int f = 0; f < 40; f++) begin
         if (f % 10 == 0)
            for (int i = 0; i < 1024; i++) wall_map[i] = ($urandom % 4 == 0);
         for (int i = 0; i < N; i++)
            if ($urandom % 3 == 0)
               load(i, rand_coord(208, TILES_X), rand_coord(96, TILES_Y), int'($urandom % 4));
         run_frame(N'($urandom), (2*N)'($urandom), ($urandom % 4 == 0), int'($urandom % N),
                   rand_coord(208, TILES_X), rand_coord(96, TILES_Y), int'($urandom % 4), -1);
      end
      check("overrun_sticky", 32'(overrun), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
